// File: rtl/text_grid_renderer.sv
// Text-grid overlay renderer: character buffer plus font-ROM lookup, 3-cycle pixel pipeline,
// with a blinking inverse-video cursor.
module text_grid_renderer #(
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 16,
  parameter int COLS         = 32,
  parameter int ROWS         = 8,
  parameter int BLINK_FRAMES = 30,
  localparam int CELLS = COLS * ROWS,
  localparam int AW    = $clog2(CELLS),
  localparam int CW    = $clog2(COLS),
  localparam int RW    = $clog2(ROWS),
  localparam int FWB   = $clog2(FONT_W),
  localparam int FHB   = $clog2(FONT_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [15:0]       pos_x,
  input  logic [15:0]       pos_y,
  input  logic [15:0]       horz_coord,
  input  logic [15:0]       vert_coord,
  input  logic              pix_valid_in,
  input  logic              frame_start,
  input  logic              cursor_en,
  input  logic [CW-1:0]     cursor_col,
  input  logic [RW-1:0]     cursor_row,
  output logic [8+FHB-1:0]  rom_addr,
  input  logic [FONT_W-1:0] rom_data,
  output logic              pixel,
  output logic              pixel_valid
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [7:0]     mem_q [CELLS];
  logic [16:0]    dx, dy;
  logic           in_range_s0, cursor_ok, hit_s0;
  logic [CW-1:0]  col_s0;
  logic [RW-1:0]  row_s0;
  logic [AW-1:0]  rd_addr;

  logic           valid_s1_q, in_range_s1_q, hit_s1_q;
  logic [FWB-1:0] bit_s1_q;
  logic [FHB-1:0] line_s1_q;
  logic [7:0]     char_s1_q;

  logic           valid_s2_q, in_range_s2_q, hit_s2_q;
  logic [FWB-1:0] bit_s2_q;
  logic [FWB-1:0] rom_idx;
  logic           pix_d;
  logic           pixel_q, pixel_valid_q;

  logic [BW-1:0]  blink_cnt_q;
  logic           blink_phase_q;

  // Negative offsets wrap to >= 2^16 in 17 bits, so one unsigned compare clips both sides.
  assign dx          = {1'b0, horz_coord} - {1'b0, pos_x};
  assign dy          = {1'b0, vert_coord} - {1'b0, pos_y};
  assign in_range_s0 = (dx < 17'(COLS * FONT_W)) && (dy < 17'(ROWS * FONT_H));
  assign col_s0      = dx[FWB +: CW];
  assign row_s0      = dy[FHB +: RW];
  assign rd_addr     = AW'(row_s0) * AW'(COLS) + AW'(col_s0);
  assign cursor_ok   = ((CW+1)'(cursor_col) < (CW+1)'(COLS)) &&
                       ((RW+1)'(cursor_row) < (RW+1)'(ROWS));
  assign hit_s0      = cursor_en && cursor_ok && (col_s0 == cursor_col) && (row_s0 == cursor_row);

  // Buffer keeps its contents through reset; the read sees pre-write data on a collision.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (AW+1)'(CELLS))) begin
      mem_q[wr_addr] <= wr_data;
    end
    char_s1_q <= mem_q[rd_addr];
  end

  assign rom_addr = in_range_s1_q ? {char_s1_q, line_s1_q} : '0;
  assign rom_idx  = FWB'(FONT_W - 1) - bit_s2_q;
  assign pix_d    = valid_s2_q && in_range_s2_q &&
                    (rom_data[rom_idx] ^ (hit_s2_q && blink_phase_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_q    <= 1'b0;
      in_range_s1_q <= 1'b0;
      hit_s1_q      <= 1'b0;
      bit_s1_q      <= '0;
      line_s1_q     <= '0;
      valid_s2_q    <= 1'b0;
      in_range_s2_q <= 1'b0;
      hit_s2_q      <= 1'b0;
      bit_s2_q      <= '0;
      pixel_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      valid_s1_q    <= pix_valid_in;
      in_range_s1_q <= in_range_s0;
      hit_s1_q      <= hit_s0;
      bit_s1_q      <= dx[FWB-1:0];
      line_s1_q     <= dy[FHB-1:0];
      valid_s2_q    <= valid_s1_q;
      in_range_s2_q <= in_range_s1_q;
      hit_s2_q      <= hit_s1_q;
      bit_s2_q      <= bit_s1_q;
      pixel_q       <= pix_d;
      pixel_valid_q <= valid_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_text_grid_renderer.sv
// Directed bench for text_grid_renderer with a behavioural synchronous font ROM and
// a shadow copy of the character buffer.
module tb_text_grid_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] pos_x, pos_y, horz_coord, vert_coord;
  logic        pix_valid_in, frame_start, cursor_en;
  logic [4:0]  cursor_col;
  logic [2:0]  cursor_row;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pixel, pixel_valid;

  logic [7:0]  model [256];
  int          errs = 0;
  int          checks = 0;

  text_grid_renderer #(.FONT_W(8), .FONT_H(16), .COLS(32), .ROWS(8), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pos_x(pos_x), .pos_y(pos_y), .horz_coord(horz_coord), .vert_coord(vert_coord),
    .pix_valid_in(pix_valid_in), .frame_start(frame_start), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  // 0x20 blank, 0x41 line0 = 0x18, 0x42 = 0xAA, everything else solid.
  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    logic [7:0] ch;
    ch = a[11:4];
    if (ch == 8'h20) return 8'h00;
    if (ch == 8'h41) return (a[3:0] == 4'd0) ? 8'h18 : 8'h00;
    if (ch == 8'h42) return 8'hAA;
    return 8'hFF;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic scan_one(input int x, input int y, output logic [11:0] ra,
                          output logic px, output logic pv);
    @(negedge clk);
    horz_coord = 16'(x); vert_coord = 16'(y); pix_valid_in = 1'b1;
    @(negedge clk);
    ra = rom_addr; pix_valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    px = pixel; pv = pixel_valid;
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] ra;
    logic        px, pv;
    logic [7:0]  pat;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pos_x = '0; pos_y = '0; horz_coord = '0; vert_coord = '0;
    pix_valid_in = 1'b0; frame_start = 1'b0; cursor_en = 1'b0;
    cursor_col = '0; cursor_row = '0;
    repeat (3) @(negedge clk);
    chk("reset_pixel", 32'(pixel), 32'd0);
    chk("reset_valid", 32'(pixel_valid), 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 256; c++) wr(c, 8'h7F);

    // Streamed 'A' line 0 at grid origin.
    wr(0, 8'h41);
    pat = 8'h18;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) chk("t1_rom_addr", 32'(rom_addr), 32'h410);
      if (i >= 3 && i < 11) begin
        chk("t1_pixel", 32'(pixel), 32'(pat[7 - (i - 3)]));
        chk("t1_valid", 32'(pixel_valid), 32'd1);
      end
      if (i == 11) begin
        chk("t1_idle_valid", 32'(pixel_valid), 32'd0);
        chk("t1_idle_pixel", 32'(pixel), 32'd0);
      end
      if (i < 8) begin
        horz_coord = 16'(i); vert_coord = 16'd0; pix_valid_in = 1'b1;
      end else begin
        pix_valid_in = 1'b0;
      end
    end

    // Clipping edges with grid at (100,50).
    pos_x = 16'd100; pos_y = 16'd50;
    scan_one(103, 50, ra, px, pv);  chk("t2_in_a_bit3", 32'(px), 32'd1);
    scan_one(99, 50, ra, px, pv);   chk("t2_left", 32'(px), 32'd0);
    chk("t2_left_valid", 32'(pv), 32'd1);
    scan_one(355, 50, ra, px, pv);  chk("t2_right_in", 32'(px), 32'd1);
    scan_one(356, 50, ra, px, pv);  chk("t2_right_out", 32'(px), 32'd0);
    chk("t2_right_rom", 32'(ra), 32'd0);
    scan_one(110, 49, ra, px, pv);  chk("t2_top", 32'(px), 32'd0);
    scan_one(110, 177, ra, px, pv); chk("t2_bottom_in", 32'(px), 32'd1);
    chk("t2_bottom_rom", 32'(ra), 32'h7FF);
    scan_one(110, 178, ra, px, pv); chk("t2_bottom_out", 32'(px), 32'd0);
    pos_x = 16'hFFF0; pos_y = 16'd0;
    scan_one(5, 0, ra, px, pv);       chk("t2_wrap_out", 32'(px), 32'd0);
    scan_one(16'hFFF3, 0, ra, px, pv); chk("t2_wrap_in", 32'(px), 32'd1);

    // Write/read collision on cell 33.
    pos_x = '0; pos_y = '0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'd33; wr_data = 8'h42;
    horz_coord = 16'd8; vert_coord = 16'd16; pix_valid_in = 1'b1;
    @(negedge clk);
    chk("t3_old_char", 32'(rom_addr), 32'h7F0);
    wr_en = 1'b0; pix_valid_in = 1'b0;
    model[33] = 8'h42;
    scan_one(8, 16, ra, px, pv); chk("t3_new_char", 32'(ra), 32'h420);
    chk("t3_new_px0", 32'(px), 32'd1);
    scan_one(9, 16, ra, px, pv); chk("t3_new_px1", 32'(px), 32'd0);

    // Cursor blink, half-period of 2 frames.
    wr(0, 8'h20); wr(1, 8'h20);
    cursor_en = 1'b1; cursor_col = '0; cursor_row = '0;
    scan_one(0, 0, ra, px, pv); chk("t4_phase0", 32'(px), 32'd0);
    pulse_frame();
    scan_one(0, 0, ra, px, pv); chk("t4_one_pulse", 32'(px), 32'd0);
    pulse_frame();
    for (int x = 0; x < 8; x++) begin
      scan_one(x, 0, ra, px, pv); chk("t4_cursor_on", 32'(px), 32'd1);
    end
    scan_one(3, 5, ra, px, pv); chk("t4_cursor_line5", 32'(px), 32'd1);
    scan_one(8, 0, ra, px, pv); chk("t4_other_cell", 32'(px), 32'd0);
    pulse_frame(); pulse_frame();
    scan_one(0, 0, ra, px, pv);  chk("t4_cursor_off", 32'(px), 32'd0);
    scan_one(7, 15, ra, px, pv); chk("t4_cursor_off2", 32'(px), 32'd0);
    cursor_en = 1'b0;

    // Strobes without wr_en, plus the last legal cell.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en = 1'b0; wr_addr = 8'(i * 7); wr_data = 8'h00;
    end
    wr(255, 8'h55);

    // Reset mid-scan.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      horz_coord = 16'(32 + i); vert_coord = 16'd32; pix_valid_in = 1'b1;
    end
    @(negedge clk);
    chk("t6_pre_pixel", 32'(pixel), 32'd1);
    chk("t6_pre_valid", 32'(pixel_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pixel", 32'(pixel), 32'd0);
    chk("t6_rst_valid", 32'(pixel_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; pix_valid_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_flushed", 32'(pixel_valid), 32'd0);
    end
    horz_coord = 16'd40; vert_coord = 16'd32; pix_valid_in = 1'b1;
    @(negedge clk); pix_valid_in = 1'b0; chk("t6_lat1", 32'(pixel_valid), 32'd0);
    @(negedge clk); chk("t6_lat2", 32'(pixel_valid), 32'd0);
    @(negedge clk); chk("t6_lat3_valid", 32'(pixel_valid), 32'd1);
    chk("t6_lat3_pixel", 32'(pixel), 32'd1);

    // Full buffer readback through rom_addr.
    pos_x = '0; pos_y = '0;
    for (int c = 0; c < 256; c++) begin
      scan_one((c % 32) * 8, (c / 32) * 16, ra, px, pv);
      chk("readback", 32'(ra), 32'({model[c], 4'h0}));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
